// File: rtl/fpadd_arbiter.sv
// rtl/fpadd_arbiter.sv - round-robin sequencer sharing one multi-cycle fpadd unit
// Grants one requester at a time, runs fpadd with a done timeout, returns a tagged sum.
module fpadd_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 511
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2:0]           resp_id,
  output logic [31:0]          resp_sum,
  output logic                 resp_err,
  output logic                 fp_start,
  output logic [31:0]          fp_a,
  output logic [31:0]          fp_b,
  input  logic [31:0]          fp_sum,
  input  logic                 fp_done
);

  localparam int          CW   = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    last_q, last_d;
  logic [2:0]    id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fp_a_q, fp_a_d, fp_b_q, fp_b_d;
  logic [31:0]   sum_q, sum_d;
  logic          err_q, err_d;

  logic [NREQ-1:0] rot;
  logic [2:0]      off;
  logic [3:0]      sumidx;
  logic [2:0]      gnt_idx;
  logic            gnt_found;
  logic [31:0]     sel_a, sel_b;

  // Rotate valids so bit 0 is the requester after last; first set bit wins.
  always_comb begin
    rot       = NREQ'({req_valid, req_valid} >> (last_q + 3'd1));
    gnt_found = 1'b0;
    off       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && rot[k]) begin
        gnt_found = 1'b1;
        off       = 3'(k);
      end
    end
    sumidx = 4'(last_q) + 4'(off) + 4'd1;
    if (sumidx >= 4'(NREQ)) begin
      sumidx = sumidx - 4'(NREQ);
    end
    gnt_idx = sumidx[2:0];
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 3'(NREQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      fp_a_q  <= '0;
      fp_b_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      fp_a_q  <= fp_a_d;
      fp_b_q  <= fp_b_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    fp_a_d  = fp_a_q;
    fp_b_d  = fp_b_q;
    sum_d   = sum_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          fp_a_d  = sel_a;
          fp_b_d  = sel_b;
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      // fp_done may still be high from the previous op during ISSUE, so only WAIT looks at it.
      WAIT: begin
        if (fp_done) begin
          sum_d   = fp_sum;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          sum_d   = QNAN;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    fp_start   = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE:  req_ready  = gnt_found ? (NREQ'(1) << gnt_idx) : '0;
      ISSUE: fp_start   = 1'b1;
      RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign fp_a     = fp_a_q;
  assign fp_b     = fp_b_q;
  assign resp_id  = id_q;
  assign resp_sum = sum_q;
  assign resp_err = err_q;

endmodule
